cache_refill: RTL and testbench

- Line-refill engine directly upstream of the cache data table (8 lines × 2 ways × 8 words of 32 bit).
- On a miss it fetches the 8-word line from main memory, critical word first.
- It writes each word into the data table through the table's write port (write/pos/lineWrite/wordWrite/dataIn).
- It forwards the critical word to the CPU early, then commits the tag for the victim way.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/refill_addr_gen.sv | 61 ++++++
 rtl/cache_refill.sv | 182 ++++++++++++++++++
 tb/tb_cache_refill.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared constants and state encoding for the cache line-refill
// engine. Address layout of a byte address:
//   [31:8] tag | [7:5] line | [4:2] word | [1:0] byte
package cache_pkg;

    localparam int WORDS     = 8;   // words per line per way (power of two)
    localparam int WORD_BITS = 3;   // log2(WORDS)
    localparam int LINE_BITS = 3;
    localparam int TAG_BITS  = 24;

    // Low bit of each address field
    localparam int WORD_LSB  = 2;
    localparam int LINE_LSB  = WORD_LSB + WORD_BITS;
    localparam int TAG_LSB   = LINE_LSB + LINE_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/refill_addr_gen.sv
// refill_addr_gen: holds the latched tag/line, the critical start word s and
// the transfer count cnt for one line refill. Produces the wrapped word index
// (s + cnt) mod WORDS and the word-aligned memory read address.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           latch miss_addr fields and clear cnt
//   adv            one word transferred; advance cnt
//   miss_addr      byte address of the missing access
//   tag, line      latched address fields
//   word_idx       current wrapped word index
//   first, last    cnt == 0 / cnt == WORDS-1
//   mem_addr       {tag, line, word_idx, 2'b00}
module refill_addr_gen
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 adv,
    input  logic [31:0]          miss_addr,
    output logic [TAG_BITS-1:0]  tag,
    output logic [LINE_BITS-1:0] line,
    output logic [WORD_BITS-1:0] word_idx,
    output logic                 first,
    output logic                 last,
    output logic [31:0]          mem_addr
);

    logic [WORD_BITS-1:0] s;
    logic [WORD_BITS-1:0] cnt;

    // Byte offset is irrelevant to a word-granular refill.
    logic unused_byte_ofs;
    assign unused_byte_ofs = ^miss_addr[WORD_LSB-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag  <= '0;
            line <= '0;
            s    <= '0;
            cnt  <= '0;
        end else if (load) begin
            tag  <= miss_addr[TAG_LSB +: TAG_BITS];
            line <= miss_addr[LINE_LSB +: LINE_BITS];
            s    <= miss_addr[WORD_LSB +: WORD_BITS];
            cnt  <= '0;
        end else if (adv) begin
            cnt  <= cnt + 1'b1;
        end
    end

    // WORDS is a power of two, so the modulo is just the natural wrap of
    // the WORD_BITS-wide sum.
    assign word_idx = s + cnt;
    assign first    = (cnt == '0);
    assign last     = (cnt == WORD_BITS'(WORDS - 1));
    // Built purely from flops, so it is stable for the whole cycle.
    assign mem_addr = {tag, line, word_idx, 2'b00};

endmodule

// File: rtl/cache_refill.sv
// cache_refill: line-refill engine in front of the cache data table.
// On an accepted miss it invalidates the victim (way, line), fetches the
// line critical-word-first from memory, writes every word into the data
// table, forwards the critical word to the CPU, then commits the tag valid.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   miss_req/addr/way        miss request (sampled only in IDLE)
//   busy, done               engine status / completion pulse
//   crit_valid, crit_data    early critical-word forward
//   mem_req/addr/ack/rdata   memory read channel
//   wr_en/way/line/word/data data table write port
//   tag_wr/valid/way/line/value tag table write port
// All outputs come from flops and clear asynchronously on rst.
module cache_refill
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_req,
    input  logic [31:0]          miss_addr,
    input  logic                 miss_way,
    output logic                 busy,
    output logic                 done,
    output logic                 crit_valid,
    output logic [31:0]          crit_data,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic                 wr_en,
    output logic                 wr_way,
    output logic [LINE_BITS-1:0] wr_line,
    output logic [WORD_BITS-1:0] wr_word,
    output logic [31:0]          wr_data,
    output logic                 tag_wr,
    output logic                 tag_valid,
    output logic                 tag_way,
    output logic [LINE_BITS-1:0] tag_line,
    output logic [TAG_BITS-1:0]  tag_value
);

    state_t state_q, state_d;
    logic   way_q;
    logic   load, adv;

    logic [TAG_BITS-1:0]  tag_q;
    logic [LINE_BITS-1:0] line_q;
    logic [WORD_BITS-1:0] word_idx;
    logic                 first, last;

    refill_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .adv       (adv),
        .miss_addr (miss_addr),
        .tag       (tag_q),
        .line      (line_q),
        .word_idx  (word_idx),
        .first     (first),
        .last      (last),
        .mem_addr  (mem_addr)
    );

    // Next values of the registered outputs
    logic                 busy_d, done_d, crit_valid_d, mem_req_d;
    logic [31:0]          crit_data_d, wr_data_d;
    logic                 wr_en_d, wr_way_d;
    logic [LINE_BITS-1:0] wr_line_d, tag_line_d;
    logic [WORD_BITS-1:0] wr_word_d;
    logic                 tag_wr_d, tag_valid_d, tag_way_d;
    logic [TAG_BITS-1:0]  tag_value_d;

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        adv          = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        crit_valid_d = 1'b0;
        crit_data_d  = '0;
        mem_req_d    = 1'b0;
        wr_en_d      = 1'b0;
        wr_way_d     = 1'b0;
        wr_line_d    = '0;
        wr_word_d    = '0;
        wr_data_d    = '0;
        tag_wr_d     = 1'b0;
        tag_valid_d  = 1'b0;
        tag_way_d    = 1'b0;
        tag_line_d   = '0;
        tag_value_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (miss_req) begin
                    state_d    = FETCH;
                    load       = 1'b1;
                    busy_d     = 1'b1;
                    mem_req_d  = 1'b1;
                    // Invalidate the victim up front so a partially
                    // written line can never hit.
                    tag_wr_d   = 1'b1;
                    tag_way_d  = miss_way;
                    tag_line_d = miss_addr[LINE_LSB +: LINE_BITS];
                end
            end
            FETCH: begin
                busy_d    = 1'b1;
                mem_req_d = 1'b1;
                if (mem_req && mem_ack) begin
                    adv       = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_way_d  = way_q;
                    wr_line_d = line_q;
                    wr_word_d = word_idx;
                    wr_data_d = mem_rdata;
                    if (first) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = mem_rdata;
                    end
                    // Final word: its write lands in COMMIT together with
                    // the tag commit and done.
                    if (last) begin
                        state_d     = COMMIT;
                        mem_req_d   = 1'b0;
                        done_d      = 1'b1;
                        tag_wr_d    = 1'b1;
                        tag_valid_d = 1'b1;
                        tag_way_d   = way_q;
                        tag_line_d  = line_q;
                        tag_value_d = tag_q;
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            way_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            mem_req    <= 1'b0;
            wr_en      <= 1'b0;
            wr_way     <= 1'b0;
            wr_line    <= '0;
            wr_word    <= '0;
            wr_data    <= '0;
            tag_wr     <= 1'b0;
            tag_valid  <= 1'b0;
            tag_way    <= 1'b0;
            tag_line   <= '0;
            tag_value  <= '0;
        end else begin
            state_q    <= state_d;
            if (load) way_q <= miss_way;
            busy       <= busy_d;
            done       <= done_d;
            crit_valid <= crit_valid_d;
            crit_data  <= crit_data_d;
            mem_req    <= mem_req_d;
            wr_en      <= wr_en_d;
            wr_way     <= wr_way_d;
            wr_line    <= wr_line_d;
            wr_word    <= wr_word_d;
            wr_data    <= wr_data_d;
            tag_wr     <= tag_wr_d;
            tag_valid  <= tag_valid_d;
            tag_way    <= tag_way_d;
            tag_line   <= tag_line_d;
            tag_value  <= tag_value_d;
        end
    end

endmodule

// File: tb/tb_cache_refill.sv
// tb_cache_refill: randomized bench for cache_refill. A transaction-level
// model tracks how many words of the current line have transferred (k) and
// predicts from the address fields alone what each output must show in the
// following cycle. Inputs are driven and outputs sampled on the falling edge.
module tb_cache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_req, miss_way, mem_ack;
    logic [31:0] miss_addr, mem_rdata;
    logic        busy, done, crit_valid, mem_req, wr_en, wr_way;
    logic        tag_wr, tag_valid, tag_way;
    logic [31:0] crit_data, mem_addr, wr_data;
    logic [2:0]  wr_line, wr_word, tag_line;
    logic [23:0] tag_value;

    always #5 clk = ~clk;

    cache_refill dut (
        .clk        (clk),
        .rst        (rst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .miss_way   (miss_way),
        .busy       (busy),
        .done       (done),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wr_en      (wr_en),
        .wr_way     (wr_way),
        .wr_line    (wr_line),
        .wr_word    (wr_word),
        .wr_data    (wr_data),
        .tag_wr     (tag_wr),
        .tag_valid  (tag_valid),
        .tag_way    (tag_way),
        .tag_line   (tag_line),
        .tag_value  (tag_value)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{busy, done, crit_valid, crit_data, mem_req, mem_addr, wr_en, wr_way,
                 wr_line, wr_word, wr_data, tag_wr, tag_valid, tag_way, tag_line, tag_value};
    endfunction

    // Quiet cycles in IDLE: nothing may move, stray mem_ack is ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            miss_req = 1'b0;
            mem_ack  = 1'($urandom);
            chk("idle_busy", busy, 0);
            chk("idle_wr",   wr_en, 0);
            chk("idle_done", done, 0);
            chk("idle_req",  mem_req, 0);
        end
    endtask

    // One refill. ack_mode: 0 = always ack, 1 = pattern 1,0,0,..., 2 = random.
    // dbase != 0 gives mem_rdata = dbase + k, else random data.
    // abort_k != 0 asserts rst once k words have transferred.
    task automatic run_refill(input logic [31:0] a, input logic w, input int ack_mode,
                              input logic [31:0] dbase, input int abort_k);
        logic [23:0] t;
        logic [2:0]  line, s, pw;
        logic [31:0] pd;
        logic        pend, ack;
        int          k, c, nwr, pk;
        t = a[31:8]; line = a[7:5]; s = a[4:2];
        k = 0; nwr = 0; pend = 1'b0; pk = 0; pw = '0; pd = '0;

        @(negedge clk);
        chk("accept_busy", busy, 0);
        miss_req = 1'b1; miss_addr = a; miss_way = w;
        mem_ack = 1'($urandom); mem_rdata = $urandom;

        for (c = 1; c <= 200; c++) begin
            @(negedge clk);
            // Requests while busy must be ignored.
            miss_req = 1'($urandom); miss_addr = $urandom; miss_way = 1'($urandom);
            chk("busy", busy, 1);
            chk("wr_en", wr_en, pend);
            if (pend) begin
                nwr++;
                chk("wr_word", wr_word, pw);
                chk("wr_data", wr_data, pd);
                chk("wr_way",  wr_way, w);
                chk("wr_line", wr_line, line);
                chk("crit_valid", crit_valid, (pk == 0));
                if (pk == 0) chk("crit_data", crit_data, pd);
            end else begin
                chk("crit_idle", crit_valid, 0);
            end

            if (k == 8) begin
                chk("done",      done, 1);
                chk("tag_wr",    tag_wr, 1);
                chk("tag_valid", tag_valid, 1);
                chk("tag_value", tag_value, t);
                chk("tag_way",   tag_way, w);
                chk("tag_line",  tag_line, line);
                chk("commit_req", mem_req, 0);
                chk("nwr", nwr, 8);
                if (ack_mode == 0) chk("latency", c, 9);
                mem_ack = 1'($urandom);
                break;
            end

            chk("fetch_done", done, 0);
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, {t, line, 3'(s + k), 2'b00});
            chk("inval_wr", tag_wr, (c == 1));
            if (c == 1) begin
                chk("inval_valid", tag_valid, 0);
                chk("inval_way",   tag_way, w);
                chk("inval_line",  tag_line, line);
            end

            if (abort_k != 0 && k == abort_k) begin
                miss_req = 1'b0; mem_ack = 1'b1;
                #2 rst = 1'b1;
                #1 chk("abort_zero", any_out(), 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_done", done, 0);
                    chk("abort_tagwr", tag_wr, 0);
                    chk("abort_wr", wr_en, 0);
                end
                rst = 1'b0;
                return;
            end

            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = (c % 3 == 1);
                default: ack = 1'($urandom);
            endcase
            mem_ack   = ack;
            mem_rdata = (dbase != 0) ? dbase + 32'(k) : $urandom;
            pend      = ack;
            if (ack) begin
                pw = 3'(s + 3'(k));
                pd = mem_rdata;
                pk = k;
                k++;
            end
        end
        if (c > 200) chk("timeout", 1, 0);
    endtask

    initial begin
        miss_req = 1'b0; miss_addr = '0; miss_way = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Asynchronous reset with no clock edge in sight.
        #2 rst = 1'b1;
        #1 chk("reset_zero", any_out(), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Basic, then back-to-back wrap-around refill accepted at cycle 10.
        run_refill(32'h0000_1A40, 1'b1, 0, 32'h0000_00A0, 0);
        run_refill(32'h0000_0058, 1'b0, 0, 32'h0, 0);
        idle(2);

        // Memory stalls 1,0,0,1,...
        run_refill(32'h1234_56EC, 1'b1, 1, 32'h0, 0);
        idle(1);

        // Reset after the 3rd ack, then a fresh refill.
        run_refill(32'hCAFE_0174, 1'b1, 0, 32'h0, 3);
        run_refill(32'hDEAD_BEE4, 1'b0, 0, 32'h0, 0);

        for (int i = 0; i < 6; i++) begin
            run_refill($urandom, 1'($urandom), 2, 32'h0, 0);
            if ($urandom_range(1) == 1) idle($urandom_range(3, 1));
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
